// File: rtl/board_mem_arbiter.sv
// Arbitrates a single-port sudoku board RAM between fixed-latency renderer reads, queued game writes and a bulk clear.
// Optional build macro RD_FORWARD_EN: reads return the youngest pending queued write to the same cell.
module board_mem_arbiter #(
    parameter int CELLS    = 81,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 4,
    parameter int WQ_DEPTH = 4
) (
    input  logic              pixel_clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_err,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(WQ_DEPTH + 1);
    localparam logic [ADDR_W:0]   CELLS_LIM = (ADDR_W+1)'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(WQ_DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < CELLS_LIM;
    endfunction

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;

    logic [ADDR_W-1:0] q_addr [WQ_DEPTH];
    logic [DATA_W-1:0] q_data [WQ_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [CNT_W-1:0]  count;

    logic rd_hit, accept, push, pop, clr_wr;

    logic vld_p0, hit_p0, vld_p1, hit_p1;

    // A read only claims the RAM slot when its address is a real cell.
    assign rd_hit   = rd_req & in_range(rd_addr);
    assign wr_ready = (count < FULL_CNT) && (state == RUN);
    assign accept   = wr_req & wr_ready;
    assign push     = accept & in_range(wr_addr);
    assign wr_err   = accept & ~in_range(wr_addr);
    assign pop      = (state != CLEAR) && (count != '0) && !rd_hit;
    assign clr_wr   = (state == CLEAR) && !rd_hit;

`ifdef RD_FORWARD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  fwd_idx;
    logic              fwd_hit_p0, fwd_hit_p1;
    logic [DATA_W-1:0] fwd_data_p0, fwd_data_p1;

    // Scan oldest to youngest so the last match wins; the write accepted this cycle is youngest of all.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            fwd_idx = rptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (q_addr[fwd_idx] == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = q_data[fwd_idx];
            end
        end
        if (push && (wr_addr == rd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data;
        end
    end
`endif

    always_ff @(posedge pixel_clk) begin
        if (push) begin
            q_addr[wptr] <= wr_addr;
            q_data[wptr] <= wr_data;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Slot owner this cycle: read, then clear, then FIFO drain.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (rd_hit) begin
            mem_addr <= rd_addr;
            mem_we   <= 1'b0;
        end else if (clr_wr) begin
            mem_addr  <= clr_ptr;
            mem_we    <= 1'b1;
            mem_wdata <= '0;
        end else if (pop) begin
            mem_addr  <= q_addr[rptr];
            mem_we    <= 1'b1;
            mem_wdata <= q_data[rptr];
        end else begin
            mem_we <= 1'b0;
        end
    end

    // p0: address on the RAM bus
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            hit_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            hit_p1 <= 1'b0;
        end else begin
            vld_p0 <= rd_req;
            hit_p0 <= rd_hit;
            // p1: RAM data arriving
            vld_p1 <= vld_p0;
            hit_p1 <= hit_p0;
        end
    end

`ifdef RD_FORWARD_EN
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hit_p0  <= 1'b0;
            fwd_data_p0 <= '0;
            fwd_hit_p1  <= 1'b0;
            fwd_data_p1 <= '0;
        end else begin
            fwd_hit_p0  <= rd_hit & fwd_hit;
            fwd_data_p0 <= fwd_data;
            fwd_hit_p1  <= fwd_hit_p0;
            fwd_data_p1 <= fwd_data_p0;
        end
    end
`endif

    // p2: registered result to the renderer
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= vld_p1;
`ifdef RD_FORWARD_EN
            if (fwd_hit_p1)
                rd_data <= fwd_data_p1;
            else
                rd_data <= hit_p1 ? mem_rdata : '0;
`else
            rd_data <= hit_p1 ? mem_rdata : '0;
`endif
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            clr_busy <= 1'b0;
            clr_ptr  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (clr_req) begin
                        state    <= DRAIN;
                        clr_busy <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (count == '0) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_wr) begin
                        if (clr_ptr == LAST_CELL) begin
                            state    <= RUN;
                            clr_busy <= 1'b0;
                        end else begin
                            clr_ptr <= clr_ptr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= RUN;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
